hpdcache_refill_splitter: RTL and testbench



---
 rtl/hpdcache_refill_splitter.sv | 145 ++++++++++++++
 tb/tb_hpdcache_refill_splitter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_refill_splitter.sv
// hpdcache_refill_splitter
//
// Splits memory read-response beats (MEM_DATA_WIDTH bits) into refill beats of
// ACCESS_WORDS cache words, the width of the data-RAM write port. Each refill
// beat carries the index of its first word within the cache line, a
// last-of-line flag, the originating transaction id and an error flag.
// A single-entry buffer holds the current memory beat. A new beat can be
// accepted in the same cycle that the final chunk of the buffered beat
// drains, so refill beats keep flowing without a bubble.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   mem_rsp_*            memory response channel (valid/ready, data, id, error, last)
//   refill_*             refill channel (valid/ready, data, word index, id, error, last)
//   protocol_err_o       sticky flag, set when mem_rsp_last_i disagrees with the beat count
//
// Optional feature (macro HPDCACHE_REFILL_SPLIT_ERR_STICKY_EN):
//   defined   - once an erroring refill beat is produced, refill_error_o stays
//               high for the rest of that line (cleared after the last beat or reset)
//   undefined - refill_error_o only flags beats sliced from an erroring memory beat
module hpdcache_refill_splitter #(
    parameter int unsigned WORD_WIDTH     = 64,
    parameter int unsigned CL_WORDS       = 8,
    parameter int unsigned ACCESS_WORDS   = 2,
    parameter int unsigned MEM_DATA_WIDTH = 256,
    parameter int unsigned MEM_ID_WIDTH   = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,

    input  logic                               mem_rsp_valid_i,
    output logic                               mem_rsp_ready_o,
    input  logic [MEM_DATA_WIDTH-1:0]          mem_rsp_data_i,
    input  logic [MEM_ID_WIDTH-1:0]            mem_rsp_id_i,
    input  logic                               mem_rsp_error_i,
    input  logic                               mem_rsp_last_i,

    output logic                               refill_valid_o,
    input  logic                               refill_ready_i,
    output logic [ACCESS_WORDS*WORD_WIDTH-1:0] refill_data_o,
    output logic [$clog2(CL_WORDS)-1:0]        refill_word_o,
    output logic [MEM_ID_WIDTH-1:0]            refill_id_o,
    output logic                               refill_error_o,
    output logic                               refill_last_o,

    output logic                               protocol_err_o
);

    localparam int unsigned BEAT_W = ACCESS_WORDS * WORD_WIDTH;
    localparam int unsigned CHUNKS = MEM_DATA_WIDTH / BEAT_W;
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int unsigned WIDX_W = $clog2(CL_WORDS);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    logic [0:0]                   state;
    logic                         buf_valid;
    logic [CHUNKS-1:0][BEAT_W-1:0] buf_data;
    logic [MEM_ID_WIDTH-1:0]      buf_id;
    logic                         buf_err;
    logic                         buf_last;
    logic [CNT_W-1:0]             chunk_cnt;
    logic [WIDX_W-1:0]            word_idx;
    logic                         protocol_err;

    logic last_chunk;
    logic mem_hs;
    logic refill_hs;

    assign buf_valid  = (state == SPLIT);
    assign last_chunk = (chunk_cnt == CNT_W'(CHUNKS - 1));
    assign refill_hs  = buf_valid && refill_ready_i;
    // Accept a new beat when empty, or when the final chunk drains this cycle.
    assign mem_rsp_ready_o = !buf_valid || (refill_ready_i && last_chunk);
    assign mem_hs          = mem_rsp_valid_i && mem_rsp_ready_o;

    assign refill_valid_o = buf_valid;
    assign refill_data_o  = buf_data[chunk_cnt];
    assign refill_word_o  = word_idx;
    assign refill_id_o    = buf_id;
    assign refill_last_o  = (word_idx == WIDX_W'(CL_WORDS - ACCESS_WORDS));
    assign protocol_err_o = protocol_err;

    // Buffer stage: control state (reset) and payload (not reset)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= EMPTY;
            chunk_cnt    <= '0;
            word_idx     <= '0;
            protocol_err <= 1'b0;
            buf_err      <= 1'b0;
            buf_last     <= 1'b0;
        end else begin
            if (refill_hs) begin
                // Word index wraps purely by count, independent of mem_rsp_last_i.
                word_idx <= refill_last_o ? '0 : word_idx + WIDX_W'(ACCESS_WORDS);
                if (last_chunk) begin
                    chunk_cnt <= '0;
                    state     <= EMPTY;
                    if (buf_last != refill_last_o) begin
                        protocol_err <= 1'b1;
                    end
                end else begin
                    chunk_cnt <= chunk_cnt + CNT_W'(1);
                end
            end
            // A same-cycle reload overrides the drain above: no bubble.
            if (mem_hs) begin
                state     <= SPLIT;
                chunk_cnt <= '0;
                buf_err   <= mem_rsp_error_i;
                buf_last  <= mem_rsp_last_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_hs) begin
            buf_data <= mem_rsp_data_i;
            buf_id   <= mem_rsp_id_i;
        end
    end

`ifdef HPDCACHE_REFILL_SPLIT_ERR_STICKY_EN
    logic err_sticky;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_sticky <= 1'b0;
        end else if (refill_hs) begin
            if (refill_last_o) begin
                err_sticky <= 1'b0;
            end else if (refill_error_o) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign refill_error_o = buf_err || err_sticky;
`else
    assign refill_error_o = buf_err;
`endif

endmodule

// File: tb/tb_hpdcache_refill_splitter.sv
module tb_hpdcache_refill_splitter;

    logic         clk;
    logic         rst_n;
    logic         mem_valid;
    logic         mem_ready;
    logic [255:0] mem_data;
    logic [3:0]   mem_id;
    logic         mem_err;
    logic         mem_last;
    logic         refill_valid;
    logic         refill_ready;
    logic [127:0] refill_data;
    logic [2:0]   refill_word;
    logic [3:0]   refill_id;
    logic         refill_err;
    logic         refill_last;
    logic         perr;

    int n_tests = 0;
    int n_fail  = 0;

    hpdcache_refill_splitter dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .mem_rsp_valid_i (mem_valid),
        .mem_rsp_ready_o (mem_ready),
        .mem_rsp_data_i  (mem_data),
        .mem_rsp_id_i    (mem_id),
        .mem_rsp_error_i (mem_err),
        .mem_rsp_last_i  (mem_last),
        .refill_valid_o  (refill_valid),
        .refill_ready_i  (refill_ready),
        .refill_data_o   (refill_data),
        .refill_word_o   (refill_word),
        .refill_id_o     (refill_id),
        .refill_error_o  (refill_err),
        .refill_last_o   (refill_last),
        .protocol_err_o  (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         mv;
        logic [255:0] md;
        logic [3:0]   id;
        logic         me;
        logic         ml;
        logic         rr;
        logic         e_mready;
        logic         e_rvalid;
        logic [127:0] e_data;
        logic [2:0]   e_word;
        logic [3:0]   e_id;
        logic         e_err;
        logic         e_last;
    } vec_t;

    localparam logic [127:0] A0 = 128'hA0A0_0000_0000_0000_0000_0000_0000_000A;
    localparam logic [127:0] A1 = 128'hA1A1_0000_0000_0000_0000_0000_0000_001A;
    localparam logic [127:0] B0 = 128'hB0B0_0000_0000_0000_0000_0000_0000_000B;
    localparam logic [127:0] B1 = 128'hB1B1_0000_0000_0000_0000_0000_0000_001B;
    localparam logic [127:0] C0 = 128'hC0C0_0000_0000_0000_0000_0000_0000_000C;
    localparam logic [127:0] C1 = 128'hC1C1_0000_0000_0000_0000_0000_0000_001C;
    localparam logic [127:0] D0 = 128'hD0D0_0000_0000_0000_0000_0000_0000_000D;
    localparam logic [127:0] D1 = 128'hD1D1_0000_0000_0000_0000_0000_0000_001D;

`ifdef HPDCACHE_REFILL_SPLIT_ERR_STICKY_EN
    localparam logic SE = 1'b1;
`else
    localparam logic SE = 1'b0;
`endif

    vec_t tbl [17];

    // Drives one full line: two mem beats, four refill beats with ready held high.
    // Beat k carries data 100+k so word order and slicing are both visible.
    task automatic run_line(input logic [3:0] id, input logic l0, input logic l1);
        int sent = 0;
        int got  = 0;
        refill_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            mem_valid = (sent < 2);
            mem_data  = {128'(100 + sent * 2 + 1), 128'(100 + sent * 2)};
            mem_id    = id;
            mem_err   = 1'b0;
            mem_last  = (sent == 0) ? l0 : l1;
            @(negedge clk);
            if (refill_valid) begin
                chk("line_word", 128'(refill_word), 128'(got * 2));
                chk("line_id",   128'(refill_id),   128'(id));
                chk("line_data", refill_data,       128'(100 + got));
                chk("line_last", 128'(refill_last), 128'(got == 3));
                got++;
            end
            if (mem_valid && mem_ready) sent++;
            @(posedge clk); #1;
        end
        mem_valid = 1'b0;
        chk("line_done", 128'(got), 128'd4);
    endtask

    initial begin
        tbl[0]  = '{1'b1, {A1, A0}, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, {B1, B0}, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, A0, 3'd0, 4'd3, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, {B1, B0}, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, A1, 3'd2, 4'd3, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, '0,       4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, B0, 3'd4, 4'd3, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, '0,       4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, B1, 3'd6, 4'd3, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, '0,       4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, {C1, C0}, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0, 4'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, {D1, D0}, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, C0, 3'd0, 4'd5, 1'b1, 1'b0};
        for (int i = 8; i < 13; i++)
            tbl[i] = '{1'b1, {D1, D0}, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C1, 3'd2, 4'd5, 1'b1, 1'b0};
        tbl[13] = '{1'b1, {D1, D0}, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, C1, 3'd2, 4'd5, 1'b1, 1'b0};
        tbl[14] = '{1'b0, '0,       4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, D0, 3'd4, 4'd5, SE,   1'b0};
        tbl[15] = '{1'b0, '0,       4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, D1, 3'd6, 4'd5, SE,   1'b1};
        tbl[16] = '{1'b0, '0,       4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0, 4'd0, 1'b0, 1'b0};

        rst_n        = 1'b0;
        mem_valid    = 1'b0;
        mem_data     = '0;
        mem_id       = '0;
        mem_err      = 1'b0;
        mem_last     = 1'b0;
        refill_ready = 1'b0;
        #2;
        chk("rst_valid", 128'(refill_valid), 128'd0);
        chk("rst_ready", 128'(mem_ready),    128'd1);
        chk("rst_last",  128'(refill_last),  128'd0);
        chk("rst_err",   128'(refill_err),   128'd0);
        chk("rst_perr",  128'(perr),         128'd0);
        chk("rst_word",  128'(refill_word),  128'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Two lines: plain one (ids 3), then backpressure + error line (ids 5)
        for (int i = 0; i < 17; i++) begin
            mem_valid    = tbl[i].mv;
            mem_data     = tbl[i].md;
            mem_id       = tbl[i].id;
            mem_err      = tbl[i].me;
            mem_last     = tbl[i].ml;
            refill_ready = tbl[i].rr;
            @(negedge clk);
            chk($sformatf("v%0d_mready", i), 128'(mem_ready),    128'(tbl[i].e_mready));
            chk($sformatf("v%0d_rvalid", i), 128'(refill_valid), 128'(tbl[i].e_rvalid));
            chk($sformatf("v%0d_word", i),   128'(refill_word),  128'(tbl[i].e_word));
            chk($sformatf("v%0d_err", i),    128'(refill_err),   128'(tbl[i].e_err));
            chk($sformatf("v%0d_last", i),   128'(refill_last),  128'(tbl[i].e_last));
            chk($sformatf("v%0d_perr", i),   128'(perr),         128'd0);
            if (tbl[i].e_rvalid) begin
                chk($sformatf("v%0d_data", i), refill_data,      tbl[i].e_data);
                chk($sformatf("v%0d_id", i),   128'(refill_id),  128'(tbl[i].e_id));
            end
            @(posedge clk); #1;
        end
        mem_valid = 1'b0;

        // Early last on beat 0 sets the sticky protocol error
        run_line(4'd7, 1'b1, 1'b1);
        chk("perr_set", 128'(perr), 128'd1);
        run_line(4'd8, 1'b0, 1'b1);
        chk("perr_sticky", 128'(perr), 128'd1);

        // Asynchronous reset after the first refill beat drops the line
        refill_ready = 1'b1;
        mem_valid    = 1'b1;
        mem_data     = {A1, A0};
        mem_id       = 4'd9;
        mem_err      = 1'b0;
        mem_last     = 1'b0;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 128'(refill_valid), 128'd1);
        @(posedge clk); #1;
        chk("pre_rst_word", 128'(refill_word), 128'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(refill_valid), 128'd0);
        chk("arst_word",  128'(refill_word),  128'd0);
        chk("arst_ready", 128'(mem_ready),    128'd1);
        chk("arst_perr",  128'(perr),         128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_line(4'd2, 1'b0, 1'b1);
        chk("post_rst_perr", 128'(perr), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
